// File: rtl/collect4_1.sv
// Round-robin collector: four 16-bit sources are gathered onto one registered valid/ready output.
// Latency: a word granted in cycle N is presented on out with out_valid=1 in cycle N+1.
// Backpressure: while the output word is held (out_valid && !out_ready), no source is granted.
module collect4_1 #(
  parameter int len = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [len-1:0] in_1,
  input  logic [len-1:0] in_2,
  input  logic [len-1:0] in_3,
  input  logic [len-1:0] in_4,
  input  logic           req_1,
  input  logic           req_2,
  input  logic           req_3,
  input  logic           req_4,
  output logic           gnt_1,
  output logic           gnt_2,
  output logic           gnt_3,
  output logic           gnt_4,
  output logic [len-1:0] out,
  output logic [1:0]     out_src,
  output logic           out_valid,
  input  logic           out_ready
);

  logic [len-1:0] r_out;
  logic [1:0]     r_out_src;
  logic           r_out_valid;
  logic [1:0]     r_last;

  logic [3:0]     w_req;
  logic           w_free;
  logic [1:0]     w_scan;
  logic           w_any;
  logic [1:0]     w_gnt_idx;
  logic [3:0]     w_gnt;
  logic [len-1:0] w_gnt_dat;

  assign w_req  = {req_4, req_3, req_2, req_1};
  assign w_free = !r_out_valid || out_ready;

  // Pick the first requester after the last granted source; grants are
  // suppressed while reset is asserted so nothing is presented as captured.
  always_comb begin
    w_any     = 1'b0;
    w_gnt_idx = 2'd0;
    w_scan    = 2'd0;
    if (rst && w_free) begin
      for (int i = 1; i <= 4; i++) begin
        w_scan = r_last + 2'(i);
        if (!w_any && w_req[w_scan]) begin
          w_any     = 1'b1;
          w_gnt_idx = w_scan;
        end
      end
    end
  end

  // One-hot grant vector and the data word of the granted source.
  always_comb begin
    w_gnt     = 4'b0000;
    w_gnt_dat = in_1;
    if (w_any) begin
      w_gnt[w_gnt_idx] = 1'b1;
    end
    case (w_gnt_idx)
      2'd0:    w_gnt_dat = in_1;
      2'd1:    w_gnt_dat = in_2;
      2'd2:    w_gnt_dat = in_3;
      default: w_gnt_dat = in_4;
    endcase
  end

  // Output register and priority pointer: load on grant, drain on take,
  // otherwise hold. The pointer only moves when a grant happens.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out       <= '0;
      r_out_src   <= 2'd0;
      r_out_valid <= 1'b0;
      r_last      <= 2'd3;
    end else if (w_any) begin
      r_out       <= w_gnt_dat;
      r_out_src   <= w_gnt_idx;
      r_out_valid <= 1'b1;
      r_last      <= w_gnt_idx;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign gnt_1     = w_gnt[0];
  assign gnt_2     = w_gnt[1];
  assign gnt_3     = w_gnt[2];
  assign gnt_4     = w_gnt[3];
  assign out       = r_out;
  assign out_src   = r_out_src;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_collect4_1.sv
// Bench for collect4_1: directed vectors with literal expectations plus a
// behavioural model compared against the DUT on every falling clock edge.
module tb_collect4_1;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] din [4];
  logic        out_ready;

  wire  [3:0]  gnt;
  wire  [15:0] dout;
  wire  [1:0]  dsrc;
  wire         dvalid;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  logic        m_valid = 1'b0;
  logic [15:0] m_out   = 16'h0000;
  int          m_src   = 0;
  int          m_last  = 3;

  logic [15:0] exp_rr  [8] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444,
                               16'h1111, 16'h2222, 16'h3333, 16'h4444};
  logic [1:0]  exp_rrs [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};

  always #5 clk = ~clk;

  collect4_1 #(.len(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_1      (din[0]),
    .in_2      (din[1]),
    .in_3      (din[2]),
    .in_4      (din[3]),
    .req_1     (req[0]),
    .req_2     (req[1]),
    .req_3     (req[2]),
    .req_4     (req[3]),
    .gnt_1     (gnt[0]),
    .gnt_2     (gnt[1]),
    .gnt_3     (gnt[2]),
    .gnt_4     (gnt[3]),
    .out       (dout),
    .out_src   (dsrc),
    .out_valid (dvalid),
    .out_ready (out_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Which source the rules say is granted now, or -1 for none.
  function automatic int pick();
    int s;
    if (!rst) return -1;
    if (m_valid && !out_ready) return -1;
    for (int i = 1; i <= 4; i++) begin
      s = (m_last + i) % 4;
      if (req[s]) return s;
    end
    return -1;
  endfunction

  always @(negedge rst) begin
    m_valid = 1'b0;
    m_out   = 16'h0000;
    m_src   = 0;
    m_last  = 3;
  end

  always @(posedge clk) begin
    int g;
    if (rst) begin
      g = pick();
      if (g >= 0) begin
        m_out   = din[g];
        m_src   = g;
        m_valid = 1'b1;
        m_last  = g;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    int         g;
    logic [3:0] eg;
    g  = pick();
    eg = (g >= 0) ? 4'(1 << g) : 4'b0000;
    check("model_gnt",   {28'd0, gnt},    {28'd0, eg});
    check("model_valid", {31'd0, dvalid}, {31'd0, m_valid});
    check("model_out",   {16'd0, dout},   {16'd0, m_out});
    check("model_src",   {30'd0, dsrc},   32'(m_src));
  end

  task automatic step_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b0;
    req       = 4'hF;
    din[0]    = 16'h1111;
    din[1]    = 16'h2222;
    din[2]    = 16'h3333;
    din[3]    = 16'h4444;
    out_ready = 1'b0;

    // Reset with every source requesting
    at_neg();
    at_neg();
    check("rst_valid", {31'd0, dvalid}, 32'd0);
    check("rst_out",   {16'd0, dout},   32'd0);
    check("rst_gnt",   {28'd0, gnt},    32'd0);

    step_edge();
    rst       = 1'b1;
    out_ready = 1'b1;
    at_neg();
    check("first_gnt", {28'd0, gnt}, 32'h1);

    // Round-robin with all requests held
    for (int k = 0; k < 8; k++) begin
      step_edge();
      at_neg();
      check("rr_out",   {16'd0, dout},   {16'd0, exp_rr[k]});
      check("rr_src",   {30'd0, dsrc},   {30'd0, exp_rrs[k]});
      check("rr_valid", {31'd0, dvalid}, 32'd1);
    end
    step_edge();              // source 0 loaded again, pointer now 0

    // Back-pressure: load 0xBEEF from source 2, then stall
    req    = 4'b0100;
    din[2] = 16'hBEEF;
    at_neg();
    check("bp_load_gnt", {28'd0, gnt}, 32'h4);
    step_edge();
    out_ready = 1'b0;
    req       = 4'b0001;
    din[0]    = 16'h1234;
    for (int k = 0; k < 5; k++) begin
      at_neg();
      check("bp_out",   {16'd0, dout},   32'hBEEF);
      check("bp_valid", {31'd0, dvalid}, 32'd1);
      check("bp_gnt",   {28'd0, gnt},    32'd0);
      step_edge();
    end
    out_ready = 1'b1;
    at_neg();
    check("bp_release_gnt", {28'd0, gnt}, 32'h1);
    step_edge();

    // Simultaneous take and load from source 3
    req    = 4'b1000;
    din[3] = 16'hA5A5;
    at_neg();
    check("bp_next_out", {16'd0, dout},   32'h1234);
    check("bp_next_src", {30'd0, dsrc},   32'd0);
    check("tl_gnt",      {28'd0, gnt},    32'h8);
    check("tl_valid0",   {31'd0, dvalid}, 32'd1);
    step_edge();

    // Move pointer to 1 via source 1
    req    = 4'b0010;
    din[1] = 16'h2222;
    at_neg();
    check("tl_out",    {16'd0, dout},   32'hA5A5);
    check("tl_src",    {30'd0, dsrc},   32'd3);
    check("tl_valid1", {31'd0, dvalid}, 32'd1);
    check("pp_set_gnt", {28'd0, gnt},   32'h2);
    step_edge();

    // Pointer at 1: sources 0 and 3 compete, 3 wins
    req    = 4'b1001;
    din[0] = 16'h0101;
    din[3] = 16'h0404;
    at_neg();
    check("pp_gnt4", {28'd0, gnt}, 32'h8);
    step_edge();
    req = 4'b0001;
    at_neg();
    check("pp_out",  {16'd0, dout}, 32'h0404);
    check("pp_src",  {30'd0, dsrc}, 32'd3);
    check("pp_gnt1", {28'd0, gnt},  32'h1);
    step_edge();

    // Hold a word, then reset between edges
    out_ready = 1'b0;
    req       = 4'hF;
    din[0]    = 16'h7777;
    din[1]    = 16'h8888;
    at_neg();
    check("mr_pre_out",   {16'd0, dout},   32'h0101);
    check("mr_pre_valid", {31'd0, dvalid}, 32'd1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("mr_valid", {31'd0, dvalid}, 32'd0);
    check("mr_out",   {16'd0, dout},   32'd0);
    check("mr_gnt",   {28'd0, gnt},    32'd0);
    step_edge();
    rst       = 1'b1;
    out_ready = 1'b1;
    at_neg();
    check("mr_first_gnt", {28'd0, gnt}, 32'h1);
    step_edge();
    at_neg();
    check("mr_out_after", {16'd0, dout}, 32'h7777);
    check("mr_src_after", {30'd0, dsrc}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
